// File: rtl/cycle_countdown_pkg.sv
// Shared constants for the multdiv iteration countdown.
// State encoding and the default iteration count used by callers.
package cycle_countdown_pkg;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;
  localparam logic [1:0] BAD  = 2'b11;

  localparam int MULTDIV_ITERATIONS = 32;

endpackage

// File: rtl/cycle_countdown_if.sv
// Control/status bundle between the multdiv FSM and the countdown.
// master = controller side, slave = countdown side.
interface cycle_countdown_if #(
  parameter int WIDTH = 6
) ();

  logic             start;
  logic             use_default;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             last;
  logic             done;

  modport master (
    output start,
    output use_default,
    output load_val,
    output en,
    output abort,
    input  count,
    input  busy,
    input  last,
    input  done
  );

  modport slave (
    input  start,
    input  use_default,
    input  load_val,
    input  en,
    input  abort,
    output count,
    output busy,
    output last,
    output done
  );

endinterface

// File: rtl/cycle_countdown_dec_reg.sv
// Down-counting register: async clear, sync load, decrement enable.
// Load wins over decrement.
module cycle_countdown_dec_reg #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (dec) begin
      q <= q - WIDTH'(1);
    end
  end

endmodule

// File: rtl/cycle_countdown.sv
// Loadable countdown with start/busy/done handshake for multdiv.
// Top holds only the IDLE/RUN/DONE FSM and output decode.
module cycle_countdown
  import cycle_countdown_pkg::*;
#(
  parameter int WIDTH        = 6,
  parameter int DEFAULT_LOAD = MULTDIV_ITERATIONS
) (
  input logic              clk,
  input logic              clr,
  cycle_countdown_if.slave bus
);

  if (DEFAULT_LOAD < 0 || DEFAULT_LOAD >= (1 << WIDTH)) begin : g_bad_default
    $error("DEFAULT_LOAD does not fit in WIDTH bits");
  end

  localparam logic [WIDTH-1:0] DEF_LOAD = WIDTH'(DEFAULT_LOAD);
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [1:0]       state;
  logic [1:0]       state_nx;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] sel_val;
  logic [WIDTH-1:0] ld_val;
  logic             ld;
  logic             dec;
  logic             is_idle;
  logic             is_run;
  logic             is_done;

  assign is_idle = (state == IDLE);
  assign is_run  = (state == RUN);
  assign is_done = (state == DONE);

  assign sel_val = bus.use_default ? DEF_LOAD : bus.load_val;

  always_comb begin
    state_nx = state;
    ld       = 1'b0;
    ld_val   = '0;
    dec      = 1'b0;
    if (bus.abort) begin
      state_nx = IDLE;
      ld       = 1'b1;
    end else begin
      unique case (1'b1)
        is_idle, is_done: begin
          state_nx = IDLE;
          if (bus.start) begin
            ld       = 1'b1;
            ld_val   = sel_val;
            // a zero load skips RUN and reports done straight away
            state_nx = (sel_val != '0) ? RUN : DONE;
          end
        end
        is_run: begin
          if (bus.en) begin
            dec = 1'b1;
            if (count == ONE) begin
              state_nx = DONE;
            end
          end
        end
        default: begin
          state_nx = IDLE;
          ld       = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  cycle_countdown_dec_reg #(
    .WIDTH (WIDTH)
  ) u_dec_reg (
    .clk  (clk),
    .clr  (clr),
    .load (ld),
    .dec  (dec),
    .d    (ld_val),
    .q    (count)
  );

  assign bus.count = count;
  assign bus.busy  = is_run;
  assign bus.done  = is_done;
  assign bus.last  = is_run && (count == ONE);

endmodule

// File: tb/tb_cycle_countdown.sv
// Self-checking bench: directed scenarios plus random traffic
// compared against a transaction-level countdown model.
module tb_cycle_countdown;

  localparam int W   = 6;
  localparam int DEF = 32;

  logic clk = 1'b0;
  logic clr = 1'b0;

  always #5 clk = ~clk;

  cycle_countdown_if #(.WIDTH(W)) bus ();

  cycle_countdown #(
    .WIDTH        (W),
    .DEFAULT_LOAD (DEF)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // reference: remaining iterations, counting flag, done-this-cycle flag
  int m_rem  = 0;
  bit m_act  = 1'b0;
  bit m_done = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    m_rem  = 0;
    m_act  = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic model_edge();
    int n;
    if (bus.abort) begin
      model_reset();
    end else if (!m_act && bus.start) begin
      n      = bus.use_default ? DEF : int'(bus.load_val);
      m_rem  = n;
      m_act  = (n != 0);
      m_done = (n == 0);
    end else if (m_act && bus.en) begin
      m_rem  = m_rem - 1;
      m_done = (m_rem == 0);
      m_act  = (m_rem != 0);
    end else begin
      m_done = 1'b0;
    end
  endtask

  task automatic compare();
    check("count", int'(bus.count), m_rem);
    check("busy", int'(bus.busy), int'(m_act));
    check("done", int'(bus.done), int'(m_done));
    check("last", int'(bus.last), int'(m_act && m_rem == 1));
  endtask

  task automatic tick();
    @(posedge clk);
    if (clr) model_edge();
    else model_reset();
    #1;
    compare();
  endtask

  task automatic idle_inputs();
    bus.start       = 1'b0;
    bus.use_default = 1'b0;
    bus.load_val    = '0;
    bus.en          = 1'b0;
    bus.abort       = 1'b0;
  endtask

  int nb;
  int nl;
  int done_e;
  int saw_done;
  int exp_cnt [6];
  bit en_pat  [6];

  initial begin
    idle_inputs();
    #2;
    compare();
    @(posedge clk);
    #1;
    clr = 1'b1;
    tick();

    // async reset in the middle of a countdown at count 17
    bus.start = 1'b1; bus.load_val = 6'd20; bus.en = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    check("pre_reset_count", int'(bus.count), 17);
    #1;
    clr = 1'b0;
    model_reset();
    #1;
    check("rst_count", int'(bus.count), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    compare();
    tick();
    clr = 1'b1;
    idle_inputs();
    repeat (3) tick();

    // default-load run with en held high
    bus.start = 1'b1; bus.use_default = 1'b1; bus.en = 1'b1;
    nb = 0; nl = 0; done_e = -1;
    for (int e = 1; e <= 40 && done_e < 0; e++) begin
      tick();
      bus.start = 1'b0;
      bus.use_default = 1'b0;
      if (bus.busy) nb++;
      if (bus.last) nl++;
      if (bus.done) done_e = e;
    end
    check("def_busy_cycles", nb, DEF);
    check("def_last_cycles", nl, 1);
    check("def_done_edge", done_e, DEF + 1);
    tick();
    check("def_back_idle_done", int'(bus.done), 0);

    // stall pattern
    exp_cnt = '{4, 3, 3, 3, 2, 1};
    en_pat  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bus.start = 1'b1; bus.load_val = 6'd4; bus.en = 1'b0;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("stall_count", int'(bus.count), exp_cnt[i]);
      check("stall_busy", int'(bus.busy), 1);
      bus.en = en_pat[i];
      tick();
    end
    check("stall_done", int'(bus.done), 1);
    tick();

    // zero load, then back-to-back start during DONE
    bus.start = 1'b1; bus.load_val = 6'd0; bus.en = 1'b1;
    tick();
    check("zero_done", int'(bus.done), 1);
    check("zero_busy", int'(bus.busy), 0);
    bus.load_val = 6'd2;
    tick();
    bus.start = 1'b0;
    check("b2b_busy", int'(bus.busy), 1);
    check("b2b_count", int'(bus.count), 2);
    tick();
    tick();
    check("b2b_done", int'(bus.done), 1);
    tick();

    // ignored restart, then abort
    bus.start = 1'b1; bus.load_val = 6'd10; bus.en = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    check("abort_pre_count", int'(bus.count), 7);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("no_reload_count", int'(bus.count), 6);
    tick();
    check("abort_at_count", int'(bus.count), 5);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    saw_done = int'(bus.done);
    check("abort_count", int'(bus.count), 0);
    check("abort_busy", int'(bus.busy), 0);
    repeat (8) begin
      tick();
      saw_done |= int'(bus.done);
    end
    check("abort_no_done", saw_done, 0);

    // random traffic with occasional async reset
    for (int i = 0; i < 800; i++) begin
      bus.start       = ($urandom_range(3) == 0);
      bus.use_default = ($urandom_range(9) == 0);
      bus.load_val    = W'($urandom_range(9));
      bus.en          = ($urandom_range(3) != 0);
      bus.abort       = ($urandom_range(29) == 0);
      if ($urandom_range(149) == 0) begin
        #1;
        clr = 1'b0;
        model_reset();
        #1;
        compare();
        tick();
        clr = 1'b1;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cycle_countdown.md
Name: cycle_countdown

Overview:
- Loadable down-counter with a start/busy/done handshake. It is the consumer-side counterpart of the up-counting T-flip-flop counter.
- The multdiv controller loads an iteration count, for example 32 for a 32-bit multiply or divide. The block then decrements once per enabled cycle and signals completion.
- The block sits between the multdiv control FSM and the datapath step logic. It provides `last` for final-iteration fix-ups and `done` for result capture.

Parameters:
- WIDTH, 6: counter width in bits. It must hold the maximum load value.
- DEFAULT_LOAD, 32: count loaded when `start` is asserted with `use_default`=1.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- clr  in  1  asynchronous, active-low reset. Low forces the reset state immediately, independent of clk.
- start  in  1  request to begin a countdown. Sampled only in IDLE or DONE.
- use_default  in  1  when 1 at start, load DEFAULT_LOAD; otherwise load `load_val`.
- load_val  in  WIDTH  iteration count to load.
- en  in  1  advance enable. Decrement happens only in RUN with en=1; en=0 stalls.
- abort  in  1  synchronous cancel; highest priority after reset.
- count  out  WIDTH  remaining iterations (registered).
- busy  out  1  high exactly while in RUN.
- last  out  1  combinational: busy AND count==1.
- done  out  1  one-cycle pulse: high exactly while in DONE.

Behaviour:
- Reset (clr=0, asynchronous):
  - state=IDLE, count=0, busy=0, done=0, last=0.
  - Deassertion takes effect at the next rising edge.
  - Reset mid-RUN discards the countdown with no done pulse.
- States: IDLE, RUN, DONE. busy and done are decoded from state only, so there are no extra flops.
- Priority per edge: abort > start/load > en/decrement.
- IDLE:
  - start=1: load count (DEFAULT_LOAD if use_default=1, else load_val).
  - If the loaded value is non-zero, go to RUN. If it is 0, go to DONE with count=0: done pulses on the next cycle with zero iterations.
  - start=0: hold.
- RUN, en=1, count>1: count <= count-1, stay in RUN.
- RUN, en=1, count==1: count <= 0, go to DONE.
- RUN, en=0: hold count and state. last remains high if count==1.
- RUN, start=1: ignored (no reload).
- DONE:
  - Lasts one cycle; done=1, count=0.
  - Next state is IDLE, unless start=1. In that case the start is accepted back-to-back: load as in IDLE and go to RUN (or stay in DONE if the load value is 0).
- abort=1 in any state: next state IDLE, count <= 0, no done pulse.
- Latency: with load value N>0 and en held high, start at cycle 0 gives busy during cycles 1..N and done at cycle N+1. Total start-to-done is N+1 edges.
- Width: decrement is modulo 2^WIDTH, but underflow is unreachable because RUN never holds count=0.
- load_val greater than or equal to 2^WIDTH is not representable. The caller's WIDTH must cover DEFAULT_LOAD, and elaboration fails if DEFAULT_LOAD >= 2^WIDTH.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'b00, RUN=2'b01, DONE=2'b10; 2'b11 is illegal and recovers to IDLE.
  - the MULTDIV_ITERATIONS=32 constant used as DEFAULT_LOAD by callers.
- One sub-module, dec_reg: a WIDTH-bit register with async active-low clear, synchronous load, and decrement enable; load has priority. The top level contains only the FSM and output decode.

Test Plan:
- Reset: drive clr=0 mid-RUN with count=17 -> count=0, busy=0, done=0 immediately. Release, idle 3 cycles -> outputs unchanged.
- Default run: start=1 with use_default=1, en held high -> busy for exactly 32 cycles, count 32..1, last high only in the count==1 cycle, done high for 1 cycle at edge 33, then IDLE.
- Stall: load_val=4, en pattern 1,0,0,1,1,1 -> count 4,3,3,3,2,1 then done. busy stays high through the stalls.
- Zero load and back-to-back:
  - load_val=0 -> done pulses the cycle after start, busy never rises.
  - Then start with load_val=2 during the DONE cycle -> RUN entered directly, done again 3 edges later.
- Abort and ignored start:
  - load_val=10; start again at count=7 -> no reload, count keeps decrementing.
  - abort at count=5 -> next edge IDLE, count=0, no done pulse ever asserted.
